// File: rtl/comp_vacc_mc_if.sv
// Control, sample and readout bundle for the multi-channel vector accumulator.
// The producer/reader side takes the master modport; the accumulator takes slave.
interface comp_vacc_mc_if #(
  parameter int INPUT_WIDTH      = 4,
  parameter int NUM_CHAN         = 2,
  parameter int VECTOR_LENGTH    = 32,
  parameter int MAX_ACC_LEN_BITS = 8
) ();
  localparam int ACC_WIDTH = INPUT_WIDTH + MAX_ACC_LEN_BITS;
  localparam int VLB       = $clog2(VECTOR_LENGTH);
  localparam int LB        = $clog2(MAX_ACC_LEN_BITS) + 1;

  logic                            sync;
  logic [LB-1:0]                   acc_len_bits;
  logic                            din_valid;
  logic [NUM_CHAN*INPUT_WIDTH-1:0] din;
  logic                            rd_buf;
  logic [VLB-1:0]                  rd_addr_a;
  logic [VLB-1:0]                  rd_addr_b;
  logic [NUM_CHAN*ACC_WIDTH-1:0]   dout_a;
  logic [NUM_CHAN*ACC_WIDTH-1:0]   dout_b;
  logic                            buf_done;
  logic                            done_buf;

  modport master (
    output sync, acc_len_bits, din_valid, din, rd_buf, rd_addr_a, rd_addr_b,
    input  dout_a, dout_b, buf_done, done_buf
  );

  modport slave (
    input  sync, acc_len_bits, din_valid, din, rd_buf, rd_addr_a, rd_addr_b,
    output dout_a, dout_b, buf_done, done_buf
  );
endinterface

// File: rtl/comp_vacc_mc.sv
// Multi-channel double-buffered vector accumulator: integrates 2^L samples per
// vector index into a ping-pong RAM and serves two independent read ports.
module comp_vacc_mc #(
  parameter int INPUT_WIDTH      = 4,
  parameter int NUM_CHAN         = 2,
  parameter int VECTOR_LENGTH    = 32,
  parameter int MAX_ACC_LEN_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  comp_vacc_mc_if.slave bus
);
  localparam int ACC_WIDTH = INPUT_WIDTH + MAX_ACC_LEN_BITS;
  localparam int VLB       = $clog2(VECTOR_LENGTH);
  localparam int LB        = $clog2(MAX_ACC_LEN_BITS) + 1;
  localparam int SW        = MAX_ACC_LEN_BITS;
  localparam int DW        = NUM_CHAN * ACC_WIDTH;
  localparam int DEPTH     = 2 * VECTOR_LENGTH;

  logic [SW-1:0]  sample_idx;
  logic [VLB-1:0] vec_idx;
  logic           active_buf;
  logic [LB-1:0]  l_q;
  logic [LB-1:0]  l_in;
  logic [SW-1:0]  last_idx;
  logic           sample_last;
  logic           write_en;
  logic           wrap;
  logic [DW-1:0]  acc_reg;
  logic [DW-1:0]  acc_sum;
  logic           buf_done_reg;
  logic           done_buf_reg;

  assign l_in = (bus.acc_len_bits > LB'(MAX_ACC_LEN_BITS)) ? LB'(MAX_ACC_LEN_BITS)
                                                           : bus.acc_len_bits;

  // Terminal sample count is 2^L_q - 1; shifting all-ones by L_q covers L_q = 0..MAX.
  assign last_idx    = ~({SW{1'b1}} << l_q);
  assign sample_last = (sample_idx == last_idx);
  assign write_en    = bus.din_valid & ~bus.sync & sample_last;
  assign wrap        = write_en & (vec_idx == VLB'(VECTOR_LENGTH - 1));

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_lane
    logic [INPUT_WIDTH-1:0] sample;
    logic [ACC_WIDTH-1:0]   din_ext;
    logic [ACC_WIDTH-1:0]   base;

    assign sample  = bus.din[gi*INPUT_WIDTH +: INPUT_WIDTH];
    assign din_ext = {{MAX_ACC_LEN_BITS{sample[INPUT_WIDTH-1]}}, sample};
    assign base    = (sample_idx == '0) ? '0 : acc_reg[gi*ACC_WIDTH +: ACC_WIDTH];
    assign acc_sum[gi*ACC_WIDTH +: ACC_WIDTH] = base + din_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_idx   <= '0;
      vec_idx      <= '0;
      active_buf   <= 1'b0;
      acc_reg      <= '0;
      l_q          <= LB'(MAX_ACC_LEN_BITS);
      buf_done_reg <= 1'b0;
      done_buf_reg <= 1'b0;
    end else begin
      buf_done_reg <= wrap;
      if (wrap) begin
        done_buf_reg <= active_buf;
      end
      // sync abandons the partial vector; the sample presented with it is dropped.
      if (bus.sync) begin
        sample_idx <= '0;
        vec_idx    <= '0;
        active_buf <= 1'b0;
        acc_reg    <= '0;
        l_q        <= l_in;
      end else if (bus.din_valid) begin
        acc_reg <= acc_sum;
        if (sample_last) begin
          sample_idx <= '0;
          vec_idx    <= vec_idx + 1'b1;
          if (wrap) begin
            active_buf <= ~active_buf;
            l_q        <= l_in;
          end
        end else begin
          sample_idx <= sample_idx + 1'b1;
        end
      end
    end
  end

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_a;
  logic [DW-1:0] ram_b;
  logic [DW-1:0] dout_a_reg;
  logic [DW-1:0] dout_b_reg;

  // Plain RAM with registered read; a read colliding with a write returns the old word.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[{active_buf, vec_idx}] <= acc_sum;
    end
    ram_a <= mem[{bus.rd_buf, bus.rd_addr_a}];
    ram_b <= mem[{bus.rd_buf, bus.rd_addr_b}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_reg <= '0;
      dout_b_reg <= '0;
    end else begin
      dout_a_reg <= ram_a;
      dout_b_reg <= ram_b;
    end
  end

  assign bus.dout_a   = dout_a_reg;
  assign bus.dout_b   = dout_b_reg;
  assign bus.buf_done = buf_done_reg;
  assign bus.done_buf = done_buf_reg;
endmodule

// File: tb/tb_comp_vacc_mc.sv
// Scoreboard bench for comp_vacc_mc: stimulus queues expected reads and buffer
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_comp_vacc_mc;
  localparam int IW   = 4;
  localparam int NC   = 2;
  localparam int VL   = 4;
  localparam int MAXL = 8;
  localparam int AW   = IW + MAXL;
  localparam int VLB  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp_vacc_mc_if #(.INPUT_WIDTH(IW), .NUM_CHAN(NC), .VECTOR_LENGTH(VL),
                    .MAX_ACC_LEN_BITS(MAXL)) bus ();

  comp_vacc_mc #(.INPUT_WIDTH(IW), .NUM_CHAN(NC), .VECTOR_LENGTH(VL),
                 .MAX_ACC_LEN_BITS(MAXL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int b; int addr; int c0; int c1;} rd_exp_t;
  typedef struct {int buf_idx; int cyc;} done_exp_t;

  rd_exp_t   qa[$];
  rd_exp_t   qb[$];
  done_exp_t qd[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic req_a = 1'b0, req_b = 1'b0;
  logic req_a_d1 = 1'b0, req_a_d2 = 1'b0, req_b_d1 = 1'b0, req_b_d2 = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_a_d1 <= req_a;
    req_a_d2 <= req_a_d1;
    req_b_d1 <= req_b;
    req_b_d2 <= req_b_d1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares read data two cycles after each issued address, and each buf_done pulse.
  rd_exp_t   ea, eb;
  done_exp_t ed;
  int a0, a1, b0, b1;
  always @(negedge clk) begin
    if (req_a_d2) begin
      a0 = int'($signed(bus.dout_a[AW-1:0]));
      a1 = int'($signed(bus.dout_a[2*AW-1:AW]));
      if (qa.size() == 0) begin
        check("unexpected read A", 1, 0);
      end else begin
        ea = qa.pop_front();
        $display("read A buf=%0d addr=%0d ch0=%0d ch1=%0d", ea.b, ea.addr, a0, a1);
        check("read A ch0", a0, ea.c0);
        check("read A ch1", a1, ea.c1);
      end
    end
    if (req_b_d2) begin
      b0 = int'($signed(bus.dout_b[AW-1:0]));
      b1 = int'($signed(bus.dout_b[2*AW-1:AW]));
      if (qb.size() == 0) begin
        check("unexpected read B", 1, 0);
      end else begin
        eb = qb.pop_front();
        $display("read B buf=%0d addr=%0d ch0=%0d ch1=%0d", eb.b, eb.addr, b0, b1);
        check("read B ch0", b0, eb.c0);
        check("read B ch1", b1, eb.c1);
      end
    end
    if (bus.buf_done) begin
      if (qd.size() == 0) begin
        check("unexpected buf_done", 1, 0);
      end else begin
        ed = qd.pop_front();
        $display("buf_done done_buf=%0d cycle=%0d", bus.done_buf, cyc);
        check("done_buf", int'(bus.done_buf), ed.buf_idx);
        check("buf_done cycle", cyc, ed.cyc);
      end
    end
  end

  task automatic drive(input logic v, input logic s, input int d0, input int d1);
    @(posedge clk); #1;
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = {IW'(d1), IW'(d0)};
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic do_sync(input int l);
    drive(1'b0, 1'b1, 0, 0);
    bus.acc_len_bits = 4'(l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  // Expected completion: pulse lands on the cycle after the edge that takes the last sample.
  task automatic expect_done(input int b);
    qd.push_back('{buf_idx: b, cyc: cyc + 1});
  endtask

  task automatic rd(input int b, input int aa, input int a0e, input int a1e,
                    input int ab, input int b0e, input int b1e);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.rd_buf    = b[0];
    bus.rd_addr_a = VLB'(aa);
    bus.rd_addr_b = VLB'(ab);
    req_a = 1'b1;
    req_b = 1'b1;
    qa.push_back('{b: b, addr: aa, c0: a0e, c1: a1e});
    qb.push_back('{b: b, addr: ab, c0: b0e, c1: b1e});
  endtask

  task automatic scen_basic();
    do_sync(2);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1, -1);
    expect_done(0);
    for (int v = 0; v < VL; v++) rd(0, v, 4, -4, VL - 1 - v, 4, -4);
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sync = 1'b0; bus.acc_len_bits = 4'd2; bus.din_valid = 1'b0; bus.din = '0;
    bus.rd_buf = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dout_a", int'(bus.dout_a), 0);
    check("reset dout_b", int'(bus.dout_b), 0);
    check("reset buf_done", int'(bus.buf_done), 0);
    check("reset done_buf", int'(bus.done_buf), 0);
    #2 rst_n = 1'b1;

    // Basic accumulation: +1/-1 over 4 samples per index.
    scen_basic();

    // Stalls: idle cycle before each valid sample; ch0 = v+s, ch1 = v-s.
    do_sync(2);
    for (int v = 0; v < VL; v++)
      for (int s = 0; s < 4; s++) begin
        drive(1'b0, 1'b0, 7, 7);
        drive(1'b1, 1'b0, v + s, v - s);
      end
    expect_done(0);
    for (int v = 0; v < VL; v++) rd(0, v, 4*v + 6, 4*v - 6, v, 4*v + 6, 4*v - 6);
    idle(4);

    // Extremes at L = MAX (request 15 clamps to 8).
    do_sync(15);
    for (int i = 0; i < 256*VL; i++) drive(1'b1, 1'b0, -8, -8);
    expect_done(0);
    for (int i = 0; i < 256*VL; i++) drive(1'b1, 1'b0, 7, 7);
    expect_done(1);
    for (int v = 0; v < VL; v++) rd(0, v, -2048, -2048, VL - 1 - v, -2048, -2048);
    for (int v = 0; v < VL; v++) rd(1, v, 1792, 1792, VL - 1 - v, 1792, 1792);
    idle(4);

    // L change 2 -> 1 mid-buffer takes effect only at the buffer boundary.
    do_sync(2);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1, -1);
      if (i == 5) bus.acc_len_bits = 4'd1;
    end
    expect_done(0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1, -1);
    expect_done(1);
    for (int v = 0; v < VL; v++) rd(0, v, 4, -4, v, 4, -4);
    for (int v = 0; v < VL; v++) rd(1, v, 2, -2, v, 2, -2);
    idle(4);

    // Mid-frame sync with a valid sample: sample dropped, no completion, clean refill.
    do_sync(2);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 3, 3);
    drive(1'b1, 1'b1, 5, 5);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 2, -2);
    expect_done(0);
    for (int v = 0; v < VL; v++) rd(0, v, 8, -8, VL - 1 - v, 8, -8);
    idle(4);

    // Asynchronous reset while buf_done, done_buf and dout are all nonzero.
    do_sync(2);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1, -1);
    expect_done(0);
    bus.rd_buf = 1'b0; bus.rd_addr_a = 2'd0; bus.rd_addr_b = 2'd1;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 2, 2);
    expect_done(1);
    @(posedge clk); #7;
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    check("async rst dout_a", int'(bus.dout_a), 0);
    check("async rst dout_b", int'(bus.dout_b), 0);
    check("async rst buf_done", int'(bus.buf_done), 0);
    check("async rst done_buf", int'(bus.done_buf), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    scen_basic();

    idle(4);
    check("pending reads A", qa.size(), 0);
    check("pending reads B", qb.size(), 0);
    check("pending buf_done", qd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/comp_vacc_mc.md
# comp_vacc_mc

Multi-channel, double-buffered vector accumulator for the X-engine correlator path. It integrates NUM_CHAN signed input lanes over a runtime-selectable 2^L samples per vector index, with input stalls via din_valid. Results are written into a ping-pong BRAM, and completion of each buffer is announced. Two independent read ports serve the downstream reorder/readout logic.

## Interface
- INPUT_WIDTH, 4: signed input sample width per lane.
- NUM_CHAN, 2: number of parallel lanes sharing one control path; lane k is din[k*INPUT_WIDTH +: INPUT_WIDTH].
- VECTOR_LENGTH, 32: vector indices per buffer; power of 2, ≥2. VLB = log2(VECTOR_LENGTH).
- MAX_ACC_LEN_BITS, 8: largest L supported. ACC_WIDTH = INPUT_WIDTH + MAX_ACC_LEN_BITS. LB = log2(MAX_ACC_LEN_BITS)+1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sync  in  1  restart the frame at buffer 0 from the next cycle.
- acc_len_bits  in  LB  L, giving 2^L samples per vector index; values > MAX_ACC_LEN_BITS clamp to MAX.
- din_valid  in  1  din is a valid sample this cycle.
- din  in  NUM_CHAN*INPUT_WIDTH  packed signed samples.
- rd_buf  in  1  buffer half to read.
- rd_addr_a, rd_addr_b  in  VLB each  read vector indices.
- dout_a, dout_b  out  NUM_CHAN*ACC_WIDTH each  packed signed sums, same lane packing as din.
- buf_done  out  1  one-cycle pulse: a buffer has been fully written.
- done_buf  out  1  index of the buffer just completed; held until the next pulse.

## Operation
- Counters, all advancing only on din_valid:
  - sample_idx (L bits).
  - vec_idx (VLB bits).
  - active_buf (1 bit).
- Order is sample-major. For v = 0..VL-1, 2^L consecutive valid samples go to vector v.
- L_q is the latched L. It loads from acc_len_bits on sync and on the cycle the last sample of a buffer is accepted. A change takes effect at the next buffer boundary, never mid-buffer.
- Per lane, each sample is sign-extended to ACC_WIDTH:
  - sample_idx==0: acc <= din_ext.
  - otherwise: acc <= acc + din_ext.
  - Full width, no saturation. ACC_WIDTH is exact for L ≤ MAX, so overflow cannot occur.
- On a valid sample with sample_idx == 2^L_q − 1:
  - write acc + din_ext into RAM address {active_buf, vec_idx}, all lanes together;
  - vec_idx increments.
- When vec_idx wraps from VL−1 to 0:
  - active_buf toggles;
  - buf_done pulses on the following cycle, with done_buf equal to the pre-toggle active_buf.
- sync has priority over din_valid:
  - the sample on the sync cycle is discarded;
  - counters clear, active_buf goes to 0, and the partial accumulation is abandoned without a write;
  - no buf_done is generated;
  - the next valid sample is s=0, v=0.
- Reads: ports A and B are fully independent and may hit the same or different addresses and buffers. Reading the active buffer is allowed and returns whatever is currently stored, with no protection.
- Reset values:
  - counters, active_buf and acc: 0;
  - L_q = MAX_ACC_LEN_BITS;
  - buf_done = 0, done_buf = 0;
  - dout_a/dout_b output registers = 0.
  - RAM contents are not reset.

## Timing
- Accumulator path: 1 cycle. The RAM write occurs on the clock edge that accepts the last sample.
- Read latency is 2 cycles: address at edge N, RAM output at N+1, dout registered at N+2.
- buf_done is asserted in the cycle after the final write edge. A read issued in that cycle returns final data, with no write/read hazard.
- Buffer period with din_valid always high: VECTOR_LENGTH·2^L cycles. It stretches by one cycle per idle (din_valid=0) cycle.
- Reset asserted mid-frame: all registers clear immediately (asynchronously). After release, behaviour is identical to post-sync, with L_q = MAX until the first sync or buffer end.
- Simultaneous sync and last-sample-of-buffer: sync wins; no write, no buf_done.

## Test plan
1. **Basic accumulation.** NUM_CHAN=2, VL=4, sync with L=2, then din ch0=+1, ch1=−1 every cycle. Required: buf_done after 16 samples with done_buf=0; reads of buffer 0, addresses 0..3, return ch0=4 and ch1=−4 two cycles after the address.
2. **Stall handling.** Same as scenario 1 with din_valid toggling every cycle and din = v+s on ch0. Required: buf_done after 32 cycles; address v reads 4v+6.
3. **Extremes.** L=MAX=8, INPUT_WIDTH=4, din=−8 on all lanes. Required: sums of −2048 exactly. Then din=+7. Required: sums of 1792. No wrap.
4. **Runtime L change.** Change acc_len_bits from 2 to 1 mid-buffer without sync. Required: the current buffer completes with 4-sample sums (din=1 gives 4), the next buffer with 2-sample sums (2), and done_buf alternates 0, 1.
5. **Mid-frame sync.** After 7 samples, assert sync together with din_valid. Required: no buf_done; that sample is dropped; the next 16 samples refill buffer 0 with clean sums.
6. **Reset.** Pull rst_n low between clock edges mid-frame. Required: dout, buf_done and done_buf go to 0 immediately. After release plus sync, scenario 1 passes unchanged.
